// File: rtl/sensor_pkg.sv
// sensor_pkg: shared channel/light indices, channel state encoding and popcount helper
// for the sensor_request_latch block.
`default_nettype none

package sensor_pkg;

  localparam int N_CH = 5;

  localparam int CH_LEFT_MAIN     = 0;
  localparam int CH_LEFT_CROSS    = 1;
  localparam int CH_TRAFFIC_CROSS = 2;
  localparam int CH_WALK_MAIN     = 3;
  localparam int CH_WALK_CROSS    = 4;

  // Light vectors are {red,yellow,green,yellow_arrow,green_arrow}, MSB first.
  localparam int LT_GARROW = 0;
  localparam int LT_YARROW = 1;
  localparam int LT_GREEN  = 2;
  localparam int LT_YELLOW = 3;
  localparam int LT_RED    = 4;

  localparam int STUCK_CNT_W = 29;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SERVED  = 2'd2
  } ch_state_e;

  function automatic logic [2:0] popcount5(input logic [N_CH-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < N_CH; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_debounce.sv
// sensor_debounce: one request channel -- 2-flop synchroniser, debounce counter,
// stable level and a one-cycle press pulse on each rising edge of the stable level.
`default_nettype none

module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_prev_q;
  logic [CNT_W-1:0] cnt_q;

  // The counter only advances while the synchronised level disagrees with the
  // accepted level, so any bounce back to the old level restarts the hold time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= raw_i;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable_o = stable_q;
  assign press_o  = stable_q & ~stable_prev_q;

endmodule

`default_nettype wire

// File: rtl/sensor_request_latch.sv
// sensor_request_latch: debounces five request switches, latches presses as pending
// requests for the traffic FSM and clears each one when its grant light shows.
// Optional stuck-switch detection is enabled by defining STUCK_DETECT_EN.
`default_nettype none

module sensor_request_latch
  import sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned STUCK_CYCLES    = 500000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_sw_i,
  input  logic [4:0]      main_lights_i,
  input  logic [4:0]      cross_lights_i,
  output logic [N_CH-1:0] sensors_o,
  output logic [2:0]      pending_count_o,
  output logic [N_CH-1:0] stuck_o
);

  if (DEBOUNCE_CYCLES < 2 || STUCK_CYCLES < 1) begin : g_param_check
    $error("sensor_request_latch: DEBOUNCE_CYCLES must be >= 2 and STUCK_CYCLES >= 1");
  end

  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] mask;
  logic            unused_lights;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw_sw_i[gi]),
      .stable_o(stable[gi]),
      .press_o (press[gi])
    );
  end

  // Both cross-street requests are served by the cross green.
  assign grant[CH_LEFT_MAIN]     = main_lights_i[LT_GARROW];
  assign grant[CH_LEFT_CROSS]    = cross_lights_i[LT_GARROW];
  assign grant[CH_TRAFFIC_CROSS] = cross_lights_i[LT_GREEN];
  assign grant[CH_WALK_MAIN]     = main_lights_i[LT_GREEN];
  assign grant[CH_WALK_CROSS]    = cross_lights_i[LT_GREEN];

  assign unused_lights = ^{main_lights_i[LT_RED], main_lights_i[LT_YELLOW], main_lights_i[LT_YARROW],
                           cross_lights_i[LT_RED], cross_lights_i[LT_YELLOW], cross_lights_i[LT_YARROW]};

`ifdef STUCK_DETECT_EN
  logic [N_CH-1:0] stuck_q;
  logic [N_CH-1:0] stuck_set;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_stuck
    logic [STUCK_CNT_W-1:0] cnt_q;
    logic                   flag_q;

    assign stuck_set[gi] = stable[gi] & ~flag_q & (cnt_q == STUCK_CNT_W'(STUCK_CYCLES - 1));
    assign stuck_q[gi]   = flag_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        flag_q <= 1'b0;
      end else if (!stable[gi]) begin
        cnt_q  <= '0;
        flag_q <= 1'b0;
      end else begin
        if (!flag_q) begin
          cnt_q <= cnt_q + STUCK_CNT_W'(1);
        end
        if (stuck_set[gi]) begin
          flag_q <= 1'b1;
        end
      end
    end
  end

  assign mask    = stuck_q | stuck_set;
  assign stuck_o = stuck_q;
`else
  logic unused_stable;
  assign unused_stable = ^stable;
  assign mask          = '0;
  assign stuck_o       = '0;
`endif

  ch_state_e       state_q [N_CH];
  ch_state_e       state_d [N_CH];
  logic [N_CH-1:0] sensors_d;

  always_comb begin
    state_d   = state_q;
    sensors_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (state_q[i])
        ST_IDLE:    if (press[i]) state_d[i] = grant[i] ? ST_SERVED : ST_PENDING;
        ST_PENDING: if (grant[i]) state_d[i] = ST_SERVED;
        ST_SERVED:  if (!grant[i]) state_d[i] = ST_IDLE;
        default:    state_d[i] = ST_IDLE;
      endcase
      if (mask[i]) begin
        state_d[i] = ST_IDLE;
      end
      sensors_d[i] = (state_d[i] == ST_PENDING);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
      end
      sensors_o       <= '0;
      pending_count_o <= '0;
    end else begin
      state_q         <= state_d;
      sensors_o       <= sensors_d;
      pending_count_o <= popcount5(sensors_d);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sensor_request_latch.sv
// tb_sensor_request_latch: directed self-checking bench for sensor_request_latch
// with DEBOUNCE_CYCLES=4 (press latency 7 edges) and STUCK_CYCLES=20.
`default_nettype none

module tb_sensor_request_latch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] raw_sw = '0;
  logic [4:0] main_lights = '0;
  logic [4:0] cross_lights = '0;
  logic [4:0] sensors;
  logic [2:0] pending_count;
  logic [4:0] stuck;

  int passed = 0;
  int total  = 0;

  sensor_request_latch #(
    .DEBOUNCE_CYCLES(4),
    .STUCK_CYCLES   (20)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .raw_sw_i       (raw_sw),
    .main_lights_i  (main_lights),
    .cross_lights_i (cross_lights),
    .sensors_o      (sensors),
    .pending_count_o(pending_count),
    .stuck_o        (stuck)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic seen;

    // 1: reset values, mid-cycle async reset, all five debounce together
    #12;
    chk("rst_sensors", {3'b0, sensors}, 8'h00);
    chk("rst_count", {5'b0, pending_count}, 8'h00);
    chk("rst_stuck", {3'b0, stuck}, 8'h00);
    rst = 1'b0;
    raw_sw = 5'b11111;
    ticks(10);
    chk("all_pending", {3'b0, sensors}, 8'h1f);
    rst = 1'b1;
    #1;
    chk("async_rst_sensors", {3'b0, sensors}, 8'h00);
    chk("async_rst_count", {5'b0, pending_count}, 8'h00);
    chk("async_rst_stuck", {3'b0, stuck}, 8'h00);
    #1;
    rst = 1'b0;
    ticks(6);
    chk("rst_redebounce_e6", {3'b0, sensors}, 8'h00);
    tick();
    chk("rst_redebounce_e7", {3'b0, sensors}, 8'h1f);
    chk("rst_redebounce_cnt", {5'b0, pending_count}, 8'h05);

    raw_sw = 5'b00000;
    main_lights = 5'b00101;
    cross_lights = 5'b00101;
    tick();
    chk("grant_all", {3'b0, sensors}, 8'h00);
    chk("grant_all_cnt", {5'b0, pending_count}, 8'h00);
    main_lights = '0;
    cross_lights = '0;
    ticks(10);

    // 2: bounce on ch2 then steady press
    seen = 1'b0;
    raw_sw = 5'b00100;
    for (int k = 0; k < 2; k++) begin tick(); seen |= |sensors; end
    raw_sw = 5'b00000;
    for (int k = 0; k < 2; k++) begin tick(); seen |= |sensors; end
    raw_sw = 5'b00100;
    for (int k = 0; k < 6; k++) begin tick(); seen |= |sensors; end
    chk("bounce_quiet", {7'b0, seen}, 8'h00);
    tick();
    chk("bounce_press_e7", {3'b0, sensors}, 8'h04);
    chk("bounce_press_cnt", {5'b0, pending_count}, 8'h01);

    // 3: shared cross green clears ch2 and ch4; press during green ignored
    raw_sw = 5'b10100;
    ticks(7);
    chk("ch2_ch4_pending", {3'b0, sensors}, 8'h14);
    chk("ch2_ch4_cnt", {5'b0, pending_count}, 8'h02);
    raw_sw = 5'b00000;
    ticks(8);
    chk("release_keeps_pending", {3'b0, sensors}, 8'h14);
    cross_lights = 5'b00100;
    tick();
    chk("cross_green_clear", {3'b0, sensors}, 8'h00);
    chk("cross_green_cnt", {5'b0, pending_count}, 8'h00);
    raw_sw = 5'b00100;
    ticks(10);
    chk("press_in_green_ignored", {3'b0, sensors}, 8'h00);
    cross_lights = 5'b10000;
    tick();
    raw_sw = 5'b00000;
    ticks(8);
    raw_sw = 5'b00100;
    ticks(6);
    chk("repress_e6", {3'b0, sensors}, 8'h00);
    tick();
    chk("repress_e7", {3'b0, sensors}, 8'h04);

    cross_lights = 5'b00100;
    tick();
    chk("ch2_clear_again", {3'b0, sensors}, 8'h00);
    cross_lights = 5'b00000;
    raw_sw = 5'b00000;
    ticks(9);

    // 4: press while grant already showing is consumed without a pulse
    main_lights = 5'b00001;
    raw_sw = 5'b00001;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(); seen |= |sensors; end
    chk("served_no_pulse", {7'b0, seen}, 8'h00);
    main_lights = 5'b00000;
    tick();
    raw_sw = 5'b00000;
    ticks(8);
    chk("served_to_idle", {3'b0, sensors}, 8'h00);
    raw_sw = 5'b00001;
    ticks(7);
    chk("ch0_pending", {3'b0, sensors}, 8'h01);
    chk("count_1", {5'b0, pending_count}, 8'h01);

    // 5: counts accumulate, two grants clear on one edge
    raw_sw = 5'b00011;
    ticks(7);
    chk("count_2", {5'b0, pending_count}, 8'h02);
    raw_sw = 5'b01011;
    ticks(7);
    chk("count_3", {5'b0, pending_count}, 8'h03);
    chk("three_pending", {3'b0, sensors}, 8'h0b);
    main_lights = 5'b00101;
    tick();
    chk("dual_grant_sensors", {3'b0, sensors}, 8'h02);
    chk("dual_grant_cnt", {5'b0, pending_count}, 8'h01);
    main_lights = 5'b00000;
    cross_lights = 5'b00001;
    tick();
    chk("ch1_clear", {3'b0, sensors}, 8'h00);
    cross_lights = 5'b00000;
    raw_sw = 5'b00000;
    ticks(9);

    // 6: held switch on ch4
    raw_sw = 5'b10000;
    ticks(7);
    chk("ch4_pending", {3'b0, sensors}, 8'h10);
    ticks(30);
`ifdef STUCK_DETECT_EN
    chk("stuck_flag", {3'b0, stuck}, 8'h10);
    chk("stuck_forces_idle", {3'b0, sensors}, 8'h00);
`else
    chk("stuck_flag", {3'b0, stuck}, 8'h00);
    chk("held_stays_pending", {3'b0, sensors}, 8'h10);
`endif
    raw_sw = 5'b00000;
    ticks(8);
    chk("stuck_released", {3'b0, stuck}, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
